// File: rtl/tlc_gs_shifter.sv
// Streams grayscale words MSB-first into a daisy-chained TLC5940 string and
// runs the gsclk/blank/latch cycle that displays the most recently completed frame.
module tlc_gs_shifter #(
   parameter int CHIPS   = 1,
   parameter int GS_BITS = 12
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [GS_BITS-1:0] gs_data,
   input  logic               gs_valid,
   output logic               gs_ready,
   input  logic               led_xerr,
   output logic               led_sclk,
   output logic               led_sin,
   output logic               led_xlat,
   output logic               led_blank,
   output logic               led_gsclk,
   output logic               led_mode,
   output logic               frame_done,
   output logic               xerr_flag
);

   localparam int WORDS = 16 * CHIPS;
   localparam int WC_W  = $clog2(WORDS + 1);
   localparam int BC_W  = (GS_BITS > 1) ? $clog2(GS_BITS) : 1;

   typedef enum logic [1:0] {RUN, BLANK_A, LATCH, BLANK_B} pwm_state_t;
   typedef enum logic [1:0] {IDLE, SHIFT, FULL} sh_state_t;

   pwm_state_t         pwmState_q, pwmState_d;
   logic [12:0]        gsCnt_q, gsCnt_d;
   sh_state_t          shState_q, shState_d;
   logic [GS_BITS-1:0] shiftReg_q, shiftReg_d;
   logic [WC_W-1:0]    wordCnt_q, wordCnt_d;
   logic [BC_W-1:0]    bitCnt_q, bitCnt_d;
   logic               phase_q, phase_d;
   logic               xerrFlag_q, xerrFlag_d;
   logic               lastBit;
   logic               latchFrame;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pwmState_q <= BLANK_A;
         gsCnt_q    <= '0;
         shState_q  <= IDLE;
         shiftReg_q <= '0;
         wordCnt_q  <= '0;
         bitCnt_q   <= '0;
         phase_q    <= 1'b0;
         xerrFlag_q <= 1'b0;
      end else begin
         pwmState_q <= pwmState_d;
         gsCnt_q    <= gsCnt_d;
         shState_q  <= shState_d;
         shiftReg_q <= shiftReg_d;
         wordCnt_q  <= wordCnt_d;
         bitCnt_q   <= bitCnt_d;
         phase_q    <= phase_d;
         xerrFlag_q <= xerrFlag_d;
      end
   end

   assign lastBit    = phase_q && (bitCnt_q == BC_W'(GS_BITS - 1));
   assign latchFrame = (pwmState_q == LATCH) && (shState_q == FULL);

   // The gsclk counter wraps 8191 -> 0 on its own, so blanking only needs to hold it at zero.
   always_comb begin
      pwmState_d = pwmState_q;
      gsCnt_d    = '0;
      xerrFlag_d = xerrFlag_q;
      case (pwmState_q)
         RUN: begin
            gsCnt_d    = gsCnt_q + 13'd1;
            xerrFlag_d = xerrFlag_q | ~led_xerr;
            if (gsCnt_q == 13'h1FFF) begin
               pwmState_d = BLANK_A;
            end
         end
         BLANK_A: pwmState_d = LATCH;
         LATCH:   pwmState_d = BLANK_B;
         BLANK_B: pwmState_d = RUN;
         default: pwmState_d = BLANK_A;
      endcase
   end

   // The final bit of a word is not shifted out, so led_sin keeps showing it while idle.
   always_comb begin
      shState_d  = shState_q;
      shiftReg_d = shiftReg_q;
      wordCnt_d  = wordCnt_q;
      bitCnt_d   = bitCnt_q;
      phase_d    = phase_q;
      case (shState_q)
         IDLE: begin
            if (gs_valid) begin
               shiftReg_d = gs_data;
               bitCnt_d   = '0;
               phase_d    = 1'b0;
               shState_d  = SHIFT;
            end
         end
         SHIFT: begin
            phase_d = ~phase_q;
            if (lastBit) begin
               wordCnt_d = wordCnt_q + WC_W'(1);
               shState_d = (wordCnt_q == WC_W'(WORDS - 1)) ? FULL : IDLE;
            end else if (phase_q) begin
               shiftReg_d = shiftReg_q << 1;
               bitCnt_d   = bitCnt_q + BC_W'(1);
            end
         end
         FULL: begin
            if (pwmState_q == LATCH) begin
               wordCnt_d = '0;
               shState_d = IDLE;
            end
         end
         default: shState_d = IDLE;
      endcase
   end

   // gs_ready is gated by reset_n so it stays low while reset is held.
   always_comb begin
      led_blank  = (pwmState_q != RUN);
      led_gsclk  = (pwmState_q == RUN) && gsCnt_q[0];
      led_xlat   = latchFrame;
      frame_done = latchFrame;
      led_sclk   = (shState_q == SHIFT) && phase_q;
      led_sin    = shiftReg_q[GS_BITS-1];
      gs_ready   = reset_n && (shState_q == IDLE);
      led_mode   = 1'b0;
      xerr_flag  = xerrFlag_q;
   end

endmodule

// File: doc/tlc_gs_shifter.md
TLC_GS_SHIFTER -- requirements
Module: tlc_gs_shifter

Interface
REQ-001 Parameter CHIPS, default 1: number of daisy-chained TLC5940 drivers; one frame is WORDS = 16*CHIPS grayscale words.
REQ-002 Parameter GS_BITS, default 12: width of each grayscale word.
REQ-003 clock  in  1  single system clock (40 MHz); all logic is on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 gs_data  in  GS_BITS  grayscale word; highest channel of the last chip comes first.
REQ-006 gs_valid  in  1  upstream word valid.
REQ-007 gs_ready  out  1  block accepts gs_data; a transfer occurs when gs_valid and gs_ready are both high on a rising edge.
REQ-008 led_xerr  in  1  driver error line, active-low.
REQ-009 led_sclk  out  1  serial shift clock to drivers.
REQ-010 led_sin  out  1  serial grayscale data, MSB first.
REQ-011 led_xlat  out  1  latch pulse to drivers.
REQ-012 led_blank  out  1  blanking; high forces outputs off and resets the driver GS counter.
REQ-013 led_gsclk  out  1  grayscale PWM reference clock.
REQ-014 led_mode  out  1  constant 0 (grayscale mode).
REQ-015 frame_done  out  1  one-cycle pulse when a frame is latched.
REQ-016 xerr_flag  out  1  sticky driver-error indicator.

Function
REQ-017 The PWM FSM has states RUN, BLANK_A, LATCH and BLANK_B.
REQ-018 RUN: a 13-bit counter counts 0..8191; led_gsclk = counter bit 0, giving exactly 4096 gsclk high pulses; led_blank = 0.
REQ-019 From RUN at count 8191 the FSM enters BLANK_A, then LATCH, then BLANK_B, one cycle each, then RUN with count 0; the full period is 8195 cycles.
REQ-020 led_blank = 1 and led_gsclk = 0 in BLANK_A, LATCH and BLANK_B.
REQ-021 In LATCH, led_xlat = 1 and frame_done = 1 only if the shift FSM is FULL; otherwise both stay 0 and the drivers keep their old data.
REQ-022 The shift FSM has states IDLE, SHIFT and FULL, plus a word counter 0..WORDS and a bit counter 0..GS_BITS-1.
REQ-023 IDLE: gs_ready = 1; on a transfer the word is loaded into the shift register and the FSM enters SHIFT.
REQ-024 SHIFT: each bit takes 2 cycles.
  - Phase 0: led_sin = current MSB, led_sclk = 0.
  - Phase 1: led_sin held, led_sclk = 1.
  - The register shifts left after phase 1.
  - gs_ready = 0.
REQ-025 A word accepted on edge T drives bit GS_BITS-1 on led_sin during cycle T+1, with the first led_sclk high during T+2; one word occupies 2*GS_BITS cycles.
REQ-026 After the last bit of a word the word counter increments.
  - If it equals WORDS, the FSM enters FULL.
  - Otherwise it enters IDLE.
  - Minimum spacing between accepted words is 2*GS_BITS+1 cycles.
REQ-027 FULL: gs_ready = 0 and led_sclk = 0; the FSM leaves FULL only in the LATCH cycle, going to IDLE with the word counter cleared.
REQ-028 Shifting proceeds during RUN and during blanking.
  - If LATCH occurs while the FSM is not FULL, the partial frame continues; no xlat is issued.
  - Words are never dropped.
REQ-029 If gs_valid is low in IDLE, the FSM stays in IDLE with led_sclk = 0 and led_sin holding its last value.
REQ-030 xerr_flag is set when led_xerr = 0 is sampled during RUN; it is ignored during blanking.
  - It is cleared only by reset.
REQ-031 led_mode = 0 at all times.

Reset
REQ-032 While reset_n = 0 at a rising edge, outputs take these values on the next cycle:
  - led_blank = 1.
  - led_sclk, led_sin, led_xlat, led_gsclk, frame_done, xerr_flag and gs_ready = 0.
  - The PWM FSM is in BLANK_A; the shift FSM is in IDLE with both counters at 0.
REQ-033 Reset asserted mid-shift or mid-PWM aborts the operation with no xlat.
  - The partial frame is discarded.
  - The first cycle after reset release is BLANK_A, and gs_ready = 1 on that cycle.

Verification
REQ-034 Reset, gs_valid = 0: led_blank = 1 for 3 cycles, then 4096 gsclk pulses with blank = 0, then 3 blank cycles with led_xlat never high.
REQ-035 CHIPS = 1, 16 words 0xA5C, 0x001 ... back-to-back: led_sin carries 192 bits MSB-first, with exactly 192 sclk rising edges.
  - At the next LATCH, xlat = 1 and frame_done = 1 for exactly one cycle.
  - gs_ready = 1 again in the following cycle.
REQ-036 Deliver the 16th word so its last bit finishes during BLANK_B: no xlat in that period; xlat occurs at the next LATCH, 8195 cycles later.
REQ-037 Hold gs_valid low for 100 cycles between words 3 and 4: sclk stays 0 during the gap, no bits are lost, and the total sclk count is still 192.
REQ-038 Pulse led_xerr = 0 for 1 cycle during RUN: xerr_flag = 1 next cycle and stays set.
  - The same pulse during BLANK_A leaves xerr_flag = 0.
REQ-039 Assert reset_n = 0 after 5 words: no xlat, led_blank = 1.
  - After release, a full 16-word frame latches normally.
